// File: rtl/usr_pkg.sv
// Universal shift register shared definitions.
// Mode encodings and the mode type.
package usr_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'd0;
  localparam mode_t MODE_SHR  = 3'd1;
  localparam mode_t MODE_SHL  = 3'd2;
  localparam mode_t MODE_LOAD = 3'd3;
  localparam mode_t MODE_ROTR = 3'd4;
  localparam mode_t MODE_ROTL = 3'd5;
  localparam mode_t MODE_CLR  = 3'd6;

endpackage

// File: rtl/usr_fill_ctr.sv
// Saturating 0..DEPTH fill counter.
// full/empty decode straight from the count register.
module usr_fill_ctr #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             set_max,
  input  logic             clr,
  output logic [CNT_W-1:0] fill,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(DEPTH);

  logic [CNT_W-1:0] cnt;

  // clear beats load beats increment; increment stops at MAX
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (set_max)
      cnt <= MAX;
    else if (inc && cnt != MAX)
      cnt <= cnt + 1'b1;
  end

  assign fill  = cnt;
  assign full  = (cnt == MAX);
  assign empty = (cnt == '0);

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: shift, rotate,
// parallel load and clear, with fill tracking.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int LANE_W = 1,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [2:0]              mode,
  input  logic [LANE_W-1:0]       sin,
  input  logic [LANE_W*DEPTH-1:0] pin,
  output logic [LANE_W*DEPTH-1:0] pout,
  output logic [LANE_W-1:0]       sout_r,
  output logic [LANE_W-1:0]       sout_l,
  output logic [CNT_W-1:0]        fill,
  output logic                    full,
  output logic                    empty
);

  logic [DEPTH-1:0][LANE_W-1:0] q;
  logic [DEPTH-1:0][LANE_W-1:0] nq;
  logic [DEPTH-1:0][LANE_W-1:0] pin_s;
  mode_t m;

  assign m     = mode_t'(mode);
  assign pin_s = pin;

  // next stage contents for the selected mode
  always_comb begin
    nq = q;
    case (m)
      MODE_SHR: begin
        nq[0] = sin;
        for (int i = 1; i < DEPTH; i++)
          nq[i] = q[i-1];
      end
      MODE_SHL: begin
        nq[DEPTH-1] = sin;
        for (int i = 0; i < DEPTH-1; i++)
          nq[i] = q[i+1];
      end
      MODE_LOAD: nq = pin_s;
      MODE_ROTR: begin
        nq[0] = q[DEPTH-1];
        for (int i = 1; i < DEPTH; i++)
          nq[i] = q[i-1];
      end
      MODE_ROTL: begin
        nq[DEPTH-1] = q[0];
        for (int i = 0; i < DEPTH-1; i++)
          nq[i] = q[i+1];
      end
      MODE_CLR: nq = '0;
      default:  nq = q;
    endcase
  end

  // stage array: reset, then enable-gated update
  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= nq;
  end

  logic inc, set_max, clr;

  assign inc     = en && (m == MODE_SHR || m == MODE_SHL);
  assign set_max = en && (m == MODE_LOAD);
  assign clr     = en && (m == MODE_CLR);

  usr_fill_ctr #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fill (
    .clk     (clk),
    .rst     (rst),
    .inc     (inc),
    .set_max (set_max),
    .clr     (clr),
    .fill    (fill),
    .full    (full),
    .empty   (empty)
  );

  assign pout   = q;
  assign sout_r = q[DEPTH-1];
  assign sout_l = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg.
// Queue-based reference model, random plus directed stimulus.
module tb_univ_shift_reg;

  localparam int LW = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic [LW-1:0] sin = '0;
  logic [LW*D-1:0] pin = '0;
  logic [LW*D-1:0] pout;
  logic [LW-1:0] sout_r, sout_l;
  logic [CW-1:0] fill;
  logic          full, empty;

  always #5 clk = ~clk;

  univ_shift_reg #(.LANE_W(LW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .sin(sin), .pin(pin), .pout(pout),
    .sout_r(sout_r), .sout_l(sout_l),
    .fill(fill), .full(full), .empty(empty)
  );

  typedef struct {
    logic [LW*D-1:0] pout;
    logic [LW-1:0]   sr;
    logic [LW-1:0]   sl;
    int              fill;
    logic            full;
    logic            empty;
    string           tag;
  } exp_t;

  exp_t sbq[$];
  int   mq[$];
  int   mfill = 0;
  int   checks = 0;
  int   passes = 0;
  string cur_tag = "init";

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  // apply one edge of stimulus and predict the resulting state
  task automatic step(input logic r, input logic e,
                      input logic [2:0] m, input logic [LW-1:0] s,
                      input logic [LW*D-1:0] p);
    int t;
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = m; sin = s; pin = p;
    if (r) begin
      foreach (mq[i]) mq[i] = 0;
      mfill = 0;
    end else if (e) begin
      case (m)
        3'd1: begin
          mq.push_front(int'(s)); t = mq.pop_back();
          mfill = (mfill < D) ? mfill + 1 : D;
        end
        3'd2: begin
          mq.push_back(int'(s)); t = mq.pop_front();
          mfill = (mfill < D) ? mfill + 1 : D;
        end
        3'd3: begin
          foreach (mq[i]) mq[i] = int'(p[i*LW +: LW]);
          mfill = D;
        end
        3'd4: begin t = mq.pop_back(); mq.push_front(t); end
        3'd5: begin t = mq.pop_front(); mq.push_back(t); end
        3'd6: begin foreach (mq[i]) mq[i] = 0; mfill = 0; end
        default: ;
      endcase
    end
    x.pout = '0;
    foreach (mq[i]) x.pout[i*LW +: LW] = LW'(mq[i]);
    x.sr    = LW'(mq[D-1]);
    x.sl    = LW'(mq[0]);
    x.fill  = mfill;
    x.full  = (mfill == D);
    x.empty = (mfill == 0);
    x.tag   = cur_tag;
    sbq.push_back(x);
  endtask

  // monitor: every edge yields an output state to compare
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        chk({x.tag, ".pout"},   64'(pout),   64'(x.pout));
        chk({x.tag, ".sout_r"}, 64'(sout_r), 64'(x.sr));
        chk({x.tag, ".sout_l"}, 64'(sout_l), 64'(x.sl));
        chk({x.tag, ".fill"},   64'(fill),   64'(x.fill));
        chk({x.tag, ".full"},   64'(full),   64'(x.full));
        chk({x.tag, ".empty"},  64'(empty),  64'(x.empty));
      end
    end
  end

  initial begin
    logic [LW*D-1:0] rp;
    logic [3:0] bits;
    int k;
    for (int i = 0; i < D; i++) mq.push_back(0);

    cur_tag = "reset0";
    step(1, 1, 3'd0, '0, '0);

    cur_tag = "pre_rand";
    for (int i = 0; i < 8; i++)
      step(0, 1, 3'($urandom_range(0, 7)), LW'($urandom),
           (LW*D)'($urandom));

    cur_tag = "rst_vs_load";
    step(1, 1, 3'd3, '0, 16'hA5C3);

    cur_tag = "shr_seq";
    bits = 4'b1011;
    for (int i = 3; i >= 0; i--)
      step(0, 1, 3'd1, LW'(bits[i]), '0);

    cur_tag = "shr_full";
    step(0, 1, 3'd1, 4'h0, '0);

    cur_tag = "load";
    step(0, 1, 3'd3, '0, 16'hA5C3);
    cur_tag = "rotr";
    for (int i = 0; i < 4; i++)
      step(0, 1, 3'd4, 4'hF, 16'h1234);

    cur_tag = "en_low";
    for (int i = 0; i < 3; i++)
      step(0, 0, 3'd1, 4'h7, 16'hFFFF);
    cur_tag = "reserved";
    for (int i = 0; i < 3; i++)
      step(0, 1, 3'd7, 4'h7, 16'hFFFF);

    cur_tag = "clr";
    step(0, 1, 3'd6, '0, '0);
    cur_tag = "shl";
    step(0, 1, 3'd2, 4'h1, '0);
    step(0, 1, 3'd2, 4'h1, '0);
    cur_tag = "clr2";
    step(0, 1, 3'd6, '0, '0);

    cur_tag = "random";
    for (int i = 0; i < 300; i++) begin
      rp = (LW*D)'($urandom);
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), LW'($urandom), rp);
    end

    @(negedge clk);
    en = 1'b0; mode = 3'd0;
    k = 0;
    while (sbq.size() > 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    #2;
    checks++;
    if (sbq.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending expected 0", sbq.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
